// File: rtl/smul_sequencer.sv
// smul_sequencer: controller in front of one smul SIMD multiplier.
//
// Streams operand pairs into the multiplier through a valid/ready handshake.
// It follows the fixed pipeline latency with a valid shift register and
// returns the results on a backpressured output stream. A configuration
// change drains the pipeline, applies the new settings and then clears smul.
//
// Parameters:
//   LATENCY      smul pipeline depth, counted in ce-enabled cycles
//   SCLR_CYCLES  number of cycles smul_sclr is held on every clear
//   DATA_W       operand / result width
//
// Ports:
//   clk, aresetn                  clock, asynchronous active-low reset
//   cfg_valid/cfg_ready           configuration request / one-cycle consume pulse
//   cfg_precision/fp/chain        requested configuration (hold until cfg_ready)
//   in_valid/in_ready/in_data/in_weight   operand stream
//   out_valid/out_ready/out_data          result stream (out_data = smul_res)
//   smul_*                        multiplier control and operand outputs, smul_res input
//   busy                          not in RUN, or results still in flight
//   cfg_err                       sticky flag: an illegal configuration was rejected
//   perf_results/perf_stalls      performance counters
//
// Optional feature, macro SMUL_SEQ_PERF_CNT_EN: when it is defined,
// perf_results counts accepted results and perf_stalls counts stalled result
// cycles, and both saturate. When it is undefined, both ports are tied to 0.
//
// The precision codes mirror precision_def.vh (INT8/16/32/64 as one-hot).
//
// state  | meaning
// CLEAR  | smul_sclr held for SCLR_CYCLES cycles, pipeline frozen
// RUN    | operands accepted, results returned
// DRAIN  | no new operands, in-flight results delivered
// APPLY  | configuration checked and latched, cfg_ready pulsed

module smul_sequencer #(
  parameter int LATENCY     = 2,
  parameter int SCLR_CYCLES = 5,
  parameter int DATA_W      = 64
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_precision,
  input  logic [1:0]        cfg_fp,
  input  logic              cfg_chain,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              smul_ce,
  output logic              smul_sclr,
  output logic [DATA_W-1:0] smul_input_data,
  output logic [DATA_W-1:0] smul_weight,
  output logic [3:0]        smul_select_precision,
  output logic [1:0]        smul_enable_fp_unit,
  output logic              smul_active_chain,
  input  logic [DATA_W-1:0] smul_res,
  output logic              busy,
  output logic              cfg_err,
  output logic [31:0]       perf_results,
  output logic [31:0]       perf_stalls
);

  localparam logic [3:0] PREC_INT8  = 4'b0001;
  localparam logic [3:0] PREC_INT16 = 4'b0010;
  localparam logic [3:0] PREC_INT32 = 4'b0100;
  localparam logic [3:0] PREC_INT64 = 4'b1000;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_APPLY = 2'd3;

  localparam int              CNT_W    = $clog2(SCLR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLR_CYCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_sclr_cnt;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] w_vld_nxt;
  logic [3:0]         r_act_prec;
  logic [1:0]         r_act_fp;
  logic               r_act_chain;
  logic               r_cfg_err;

  logic w_pipe_on;
  logic w_adv;
  logic w_accept;
  logic w_prec_ok;
  logic w_fp_ok;
  logic w_cfg_legal;

  // The pipeline may advance only when its last stage is empty or is being
  // consumed. With no skid buffer, a stalled result is held by freezing smul.
  assign w_pipe_on = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_adv     = !r_vld[LATENCY-1] || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign smul_ce         = w_pipe_on && w_adv;
  assign smul_sclr       = (r_state == ST_CLEAR);
  assign in_ready        = (r_state == ST_RUN) && w_adv && !cfg_valid;
  assign cfg_ready       = (r_state == ST_APPLY);
  assign out_valid       = r_vld[LATENCY-1];
  assign out_data        = smul_res;
  assign smul_input_data = in_data;
  assign smul_weight     = in_weight;
  assign busy            = (r_state != ST_RUN) || (|r_vld);
  assign cfg_err         = r_cfg_err;

  assign smul_select_precision = r_act_prec;
  assign smul_enable_fp_unit   = r_act_fp;
  assign smul_active_chain     = r_act_chain;

  always_comb begin
    w_prec_ok = 1'b0;
    case (cfg_precision)
      PREC_INT8, PREC_INT16, PREC_INT32, PREC_INT64: w_prec_ok = 1'b1;
      default:                                       w_prec_ok = 1'b0;
    endcase
  end

  // The FP unit exists only for the 16- and 32-bit lane widths.
  assign w_fp_ok     = (cfg_fp == 2'd0) || (cfg_precision == PREC_INT16) ||
                       (cfg_precision == PREC_INT32);
  assign w_cfg_legal = w_prec_ok && w_fp_ok;

  // Bubbles shift in on every advancing cycle without an accepted operand.
  always_comb begin
    w_vld_nxt = r_vld;
    if (smul_ce) begin
      w_vld_nxt[0] = w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        w_vld_nxt[i] = r_vld[i-1];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_sclr_cnt == CNT_LAST) w_state_nxt = ST_RUN;
      ST_RUN:   if (cfg_valid) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_vld == '0) w_state_nxt = ST_APPLY;
      ST_APPLY: w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_CLEAR;
      r_sclr_cnt  <= '0;
      r_vld       <= '0;
      r_act_prec  <= PREC_INT64;
      r_act_fp    <= 2'd0;
      r_act_chain <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= w_vld_nxt;

      if (r_state == ST_CLEAR && r_sclr_cnt != CNT_LAST) begin
        r_sclr_cnt <= r_sclr_cnt + CNT_W'(1);
      end else begin
        r_sclr_cnt <= '0;
      end

      if (r_state == ST_APPLY) begin
        if (w_cfg_legal) begin
          r_act_prec  <= cfg_precision;
          r_act_fp    <= cfg_fp;
          r_act_chain <= cfg_chain;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

`ifdef SMUL_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_results;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_perf_results <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (out_valid && out_ready && r_perf_results != 32'hFFFF_FFFF) begin
        r_perf_results <= r_perf_results + 32'd1;
      end
      if (out_valid && !out_ready && r_perf_stalls != 32'hFFFF_FFFF) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_results = r_perf_results;
  assign perf_stalls  = r_perf_stalls;
`else
  assign perf_results = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_smul_sequencer.sv
// Testbench for smul_sequencer. It uses a two-stage, ce-gated behavioural
// smul (res = data * weight, cleared by sclr), a per-cycle vector table for
// streaming and backpressure, and hand-written sequences for reset,
// reconfiguration, illegal configuration and the cfg/data collision.

module tb_smul_sequencer;

  localparam logic [3:0]  P_INT8  = 4'b0001;
  localparam logic [3:0]  P_INT16 = 4'b0010;
  localparam logic [3:0]  P_INT32 = 4'b0100;
  localparam logic [3:0]  P_INT64 = 4'b1000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DBASE   = 64'hcafe_cafe_cafe_cafe;

  logic        clk;
  logic        aresetn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_precision;
  logic [1:0]  cfg_fp;
  logic        cfg_chain;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_weight;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        smul_ce;
  logic        smul_sclr;
  logic [63:0] smul_input_data;
  logic [63:0] smul_weight;
  logic [3:0]  smul_select_precision;
  logic [1:0]  smul_enable_fp_unit;
  logic        smul_active_chain;
  logic [63:0] smul_res;
  logic        busy;
  logic        cfg_err;
  logic [31:0] perf_results;
  logic [31:0] perf_stalls;

  smul_sequencer #(.LATENCY(2), .SCLR_CYCLES(5), .DATA_W(64)) dut (
    .clk                   (clk),
    .aresetn               (aresetn),
    .cfg_valid             (cfg_valid),
    .cfg_ready             (cfg_ready),
    .cfg_precision         (cfg_precision),
    .cfg_fp                (cfg_fp),
    .cfg_chain             (cfg_chain),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .in_weight             (in_weight),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .smul_ce               (smul_ce),
    .smul_sclr             (smul_sclr),
    .smul_input_data       (smul_input_data),
    .smul_weight           (smul_weight),
    .smul_select_precision (smul_select_precision),
    .smul_enable_fp_unit   (smul_enable_fp_unit),
    .smul_active_chain     (smul_active_chain),
    .smul_res              (smul_res),
    .busy                  (busy),
    .cfg_err               (cfg_err),
    .perf_results          (perf_results),
    .perf_stalls           (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural smul: two ce-gated stages, synchronous clear
  logic [63:0] m_s1;
  logic [63:0] m_s2;
  always_ff @(posedge clk) begin
    if (smul_sclr) begin
      m_s1 <= '0;
      m_s2 <= '0;
    end else if (smul_ce) begin
      m_s1 <= smul_input_data * smul_weight;
      m_s2 <= m_s1;
    end
  end
  assign smul_res = m_s2;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // multiplying by all-ones is two's complement negation
  function automatic logic [63:0] neg(input logic [63:0] d);
    return ~d + 64'd1;
  endfunction

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ce;
    logic        e_ov;
    logic [63:0] e_od;
    logic        e_busy;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic iv, input int di, input logic ordy,
                              input logic ir, input logic ce, input logic ov,
                              input int pi, input logic bsy);
    vec_t v;
    v.iv     = iv;
    v.d      = (di < 0) ? 64'h0 : DBASE + 64'(di);
    v.ordy   = ordy;
    v.e_ir   = ir;
    v.e_ce   = ce;
    v.e_ov   = ov;
    v.e_od   = (pi < 0) ? 64'h0 : neg(DBASE + 64'(pi));
    v.e_busy = bsy;
    return v;
  endfunction

  // results of the configuration sequence
  int          pulses;
  int          sclr_n;
  int          n_res;
  int          n_pre;
  int          early_acc;
  logic        done;
  logic        ir_at_cfg;
  logic        ir_done;
  logic [3:0]  prec_at_apply;
  logic [63:0] res_q[4];

  task automatic cfg_seq(input logic [3:0] p, input logic [1:0] f, input logic c,
                         input logic iv, input logic [63:0] d);
    pulses = 0; sclr_n = 0; n_res = 0; n_pre = 0; early_acc = 0;
    done = 1'b0; ir_done = 1'b0; prec_at_apply = 4'h0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_precision = p; cfg_fp = f; cfg_chain = c;
    in_valid = iv; in_data = d; out_ready = 1'b1;
    #1;
    ir_at_cfg = in_ready;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (pulses > 0) cfg_valid = 1'b0;
        #1;
      end
      if (in_valid && in_ready && pulses == 0) early_acc++;
      if (out_valid) begin
        if (n_res < 4) res_q[n_res] = out_data;
        n_res++;
        if (pulses == 0) n_pre++;
      end
      if (cfg_ready) begin
        pulses++;
        prec_at_apply = smul_select_precision;
      end
      if (smul_sclr) sclr_n++;
      if (pulses > 0 && !cfg_ready && !smul_sclr) begin
        done    = 1'b1;
        ir_done = in_ready;
      end
    end
    chk("cfg_seq completes", 64'(done), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    aresetn = 1'b0; cfg_valid = 1'b0; cfg_precision = P_INT64; cfg_fp = 2'd0;
    cfg_chain = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = ONES;
    out_ready = 1'b1;

    vt[0]  = mk(1, 0, 1, 1, 1, 0, -1, 0);
    vt[1]  = mk(1, 1, 1, 1, 1, 0, -1, 1);
    vt[2]  = mk(1, 2, 1, 1, 1, 1, 0, 1);
    vt[3]  = mk(1, 3, 1, 1, 1, 1, 1, 1);
    vt[4]  = mk(1, 4, 0, 0, 0, 1, 2, 1);
    vt[5]  = mk(1, 4, 0, 0, 0, 1, 2, 1);
    vt[6]  = mk(1, 4, 0, 0, 0, 1, 2, 1);
    vt[7]  = mk(1, 4, 0, 0, 0, 1, 2, 1);
    vt[8]  = mk(1, 4, 1, 1, 1, 1, 2, 1);
    vt[9]  = mk(1, 5, 1, 1, 1, 1, 3, 1);
    vt[10] = mk(1, 6, 1, 1, 1, 1, 4, 1);
    vt[11] = mk(1, 7, 1, 1, 1, 1, 5, 1);
    vt[12] = mk(0, -1, 1, 1, 1, 1, 6, 1);
    vt[13] = mk(0, -1, 1, 1, 1, 1, 7, 1);
    vt[14] = mk(0, -1, 1, 1, 1, 0, -1, 0);

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst smul_sclr", 64'(smul_sclr), 64'd1);
    chk("rst smul_ce", 64'(smul_ce), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst cfg_err", 64'(cfg_err), 64'd0);
    chk("rst busy", 64'(busy), 64'd1);
    chk("rst precision", 64'(smul_select_precision), 64'(P_INT64));

    // reset again partway through the clear, then count a full clear
    @(negedge clk); aresetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk); aresetn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!smul_sclr) break;
      cnt++;
      @(negedge clk);
    end
    chk("sclr cycles after reset", 64'(cnt), 64'd5);
    chk("run in_ready", 64'(in_ready), 64'd1);
    chk("run busy", 64'(busy), 64'd0);
    chk("run precision", 64'(smul_select_precision), 64'(P_INT64));
    chk("run fp", 64'(smul_enable_fp_unit), 64'd0);

    // streaming with a four-cycle backpressure hold
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      in_valid = vt[r].iv; in_data = vt[r].d; out_ready = vt[r].ordy;
      #1;
      chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(vt[r].e_ir));
      chk($sformatf("row%0d smul_ce", r), 64'(smul_ce), 64'(vt[r].e_ce));
      chk($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(vt[r].e_ov));
      chk($sformatf("row%0d busy", r), 64'(busy), 64'(vt[r].e_busy));
      if (vt[r].e_ov) chk($sformatf("row%0d out_data", r), out_data, vt[r].e_od);
    end

    // legal reconfiguration with two results in flight
    @(negedge clk);
    in_valid = 1'b1; in_data = DBASE + 64'd16;
    #1; chk("pre-cfg accept 0", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_data = DBASE + 64'd17;
    #1; chk("pre-cfg accept 1", 64'(in_ready), 64'd1);
    cfg_seq(P_INT16, 2'd3, 1'b1, 1'b0, 64'h0);
    chk("cfg1 in_ready at request", 64'(ir_at_cfg), 64'd0);
    chk("cfg1 results before cfg_ready", 64'(n_pre), 64'd2);
    chk("cfg1 results total", 64'(n_res), 64'd2);
    chk("cfg1 result 0", res_q[0], neg(DBASE + 64'd16));
    chk("cfg1 result 1", res_q[1], neg(DBASE + 64'd17));
    chk("cfg1 cfg_ready pulses", 64'(pulses), 64'd1);
    chk("cfg1 precision during apply", 64'(prec_at_apply), 64'(P_INT64));
    chk("cfg1 sclr cycles", 64'(sclr_n), 64'd5);
    chk("cfg1 precision", 64'(smul_select_precision), 64'(P_INT16));
    chk("cfg1 fp", 64'(smul_enable_fp_unit), 64'd3);
    chk("cfg1 chain", 64'(smul_active_chain), 64'd1);
    chk("cfg1 cfg_err", 64'(cfg_err), 64'd0);
    chk("cfg1 busy", 64'(busy), 64'd0);

    // illegal configuration: FP with INT8
    cfg_seq(P_INT8, 2'd1, 1'b0, 1'b0, 64'h0);
    chk("cfg2 cfg_ready pulses", 64'(pulses), 64'd1);
    chk("cfg2 cfg_err", 64'(cfg_err), 64'd1);
    chk("cfg2 precision kept", 64'(smul_select_precision), 64'(P_INT16));
    chk("cfg2 fp kept", 64'(smul_enable_fp_unit), 64'd3);
    chk("cfg2 chain kept", 64'(smul_active_chain), 64'd1);
    chk("cfg2 sclr cycles", 64'(sclr_n), 64'd5);

    // cfg_valid and in_valid in the same RUN cycle
    cfg_seq(P_INT32, 2'd0, 1'b0, 1'b1, DBASE + 64'd32);
    chk("cfg3 in_ready at request", 64'(ir_at_cfg), 64'd0);
    chk("cfg3 early accepts", 64'(early_acc), 64'd0);
    chk("cfg3 in_ready after clear", 64'(ir_done), 64'd1);
    chk("cfg3 precision", 64'(smul_select_precision), 64'(P_INT32));
    chk("cfg3 fp", 64'(smul_enable_fp_unit), 64'd0);
    chk("cfg3 cfg_err sticky", 64'(cfg_err), 64'd1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("cfg3 out_valid", 64'(out_valid), 64'd1);
    chk("cfg3 out_data", out_data, neg(DBASE + 64'd32));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/smul_sequencer.md
Name: smul_sequencer

Overview:
- Controller in front of one smul SIMD multiplier instance.
- Accepts operand pairs over a valid/ready stream and drives the multiplier's ce, sclr and precision/FP/chain configuration.
- Tracks the fixed pipeline latency and returns results on a backpressured output stream.
- Reconfigures precision safely: drain the pipeline, clear it, then resume.

Parameters:
- LATENCY, 2: smul pipeline depth in ce-enabled cycles.
- SCLR_CYCLES, 5: number of cycles smul_sclr is held on every clear.
- DATA_W, 64: operand/result width.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- cfg_valid  in  1  new configuration request
- cfg_ready  out  1  configuration consumed (one-cycle pulse)
- cfg_precision  in  4  `INT8/`INT16/`INT32/`INT64 (precision_def.vh)
- cfg_fp  in  2  requested enable_fp_unit value
- cfg_chain  in  1  requested active_chain value
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted
- in_data  in  DATA_W  input operand
- in_weight  in  DATA_W  weight operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  result (equals smul_res)
- smul_ce  out  1  to smul ce
- smul_sclr  out  1  to smul sclr
- smul_input_data  out  DATA_W  to smul input_data
- smul_weight  out  DATA_W  to smul weight
- smul_select_precision  out  4  to smul select_precision
- smul_enable_fp_unit  out  2  to smul enable_fp_unit
- smul_active_chain  out  1  to smul active_chain
- smul_res  in  DATA_W  from smul res_mac_next
- busy  out  1  state is not RUN, or the pipeline is non-empty
- cfg_err  out  1  sticky: illegal configuration rejected

Behaviour:
- Reset (aresetn=0, asynchronous):
  - state=CLEAR, sclr counter=0, vld[LATENCY-1:0]=0.
  - Active configuration = `INT64 / fp 0 / chain 0.
  - Outputs: smul_ce=0, smul_sclr=1, in_ready=0, out_valid=0, cfg_ready=0, cfg_err=0, busy=1.
- FSM states: CLEAR, RUN, DRAIN, APPLY.
- CLEAR:
  - smul_sclr=1, smul_ce=0; the counter increments each cycle.
  - After SCLR_CYCLES cycles, go to RUN and reset the counter.
  - Reset deasserted mid-clear restarts CLEAR from count 0.
- RUN:
  - adv = !vld[LATENCY-1] | out_ready; smul_ce = adv.
  - in_ready = adv & !cfg_valid (combinational on out_ready).
  - On each adv cycle: vld shifts, and vld[0] = in_valid & in_ready. A bubble is inserted when no valid input is present.
  - smul_input_data/smul_weight pass in_data/in_weight through combinationally.
  - out_valid = vld[LATENCY-1]; out_data = smul_res.
  - With out_ready=0, ce=0 freezes smul, so the result stays stable (no skid buffer).
- cfg_valid seen in RUN:
  - in_ready=0 that same cycle (configuration wins over data).
  - Next state is DRAIN.
- DRAIN:
  - in_ready=0; smul_ce = adv, bubbles shift in; outputs are still delivered.
  - When vld==0, go to APPLY.
  - If the pipeline is already empty, DRAIN lasts exactly one cycle.
- APPLY (one cycle):
  - cfg_ready=1.
  - Legality check: cfg_fp!=0 is legal only with `INT16 or `INT32; cfg_precision must be one of the four codes.
  - Legal: latch cfg_* into the active configuration.
  - Illegal: keep the old configuration and set cfg_err (cleared only by reset).
  - Next state is CLEAR in both cases.
- cfg_* must be held stable from cfg_valid until cfg_ready.
- smul_select_precision/enable_fp_unit/active_chain are registered from the active configuration and change only in APPLY.
- busy = (state!=RUN) | (vld!=0).

Optional Feature:
- Macro: SMUL_SEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_results[31:0] (count of out_valid&out_ready) and perf_stalls[31:0] (count of out_valid&!out_ready).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 with aresetn.
- When not defined: both ports exist but are tied to 0, and no counter logic is present.

Test Plan:
- Reset release: observe smul_sclr=1 for exactly 5 cycles, then RUN with in_ready=1, busy=0, smul_select_precision=`INT64.
- RUN stream, back-to-back: in_data=64'hcafecafecafecafe, weight=64'hFFFFFFFFFFFFFFFF, 8 pairs, out_ready=1.
  - out_valid rises 2 cycles after the first accept.
  - 8 results arrive consecutively, each equal to the golden smul model.
- Backpressure: hold out_ready=0 for 4 cycles mid-stream.
  - smul_ce=0 and in_ready=0 during the hold.
  - out_data stays constant; no result is lost or duplicated.
- Reconfiguration to `INT16 with cfg_fp=2'd3 while 2 results are in flight: those 2 results are delivered first, then cfg_ready pulses once, then 5 cycles of sclr, then RUN with the new configuration.
- Illegal configuration (`INT8, cfg_fp=1):
  - cfg_ready pulses and cfg_err=1.
  - Active precision is unchanged; a clear still occurs.
- Simultaneous cfg_valid and in_valid in RUN: in_ready=0 that cycle, and the operand is accepted only after the new configuration is active.
